// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: register count,
// index width, writeback source identifiers and the hardwired-zero register.
package wb_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 2 ** REG_ADDR_WIDTH;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_id_t;

  localparam logic [REG_ADDR_WIDTH-1:0] X0_ADDR = '0;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bitmap for pending register writes, with RAW/WAW hazard lookups.
// Define WBARB_WB_BYPASS_EN to let a writeback firing this cycle release its register early.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int AW = REG_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic                 wb_fire,
  input  logic [AW-1:0]        wb_rd,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 issue_ready,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 wb_unclaimed,
  output logic [(2**AW)-1:0]   busy_map
);

  localparam int N = 2 ** AW;

  logic [N-1:0] busy_q;
  logic [N-1:0] clr_mask;
  logic [N-1:0] set_mask;
  logic [N-1:0] release_mask;
  logic [N-1:0] eff_busy;
  logic         issue_fire;

  always_comb begin
    clr_mask     = '0;
    set_mask     = '0;
    release_mask = '0;
    if (wb_fire && (wb_rd != AW'(X0_ADDR))) clr_mask[wb_rd] = 1'b1;
`ifdef WBARB_WB_BYPASS_EN
    release_mask = clr_mask;
`endif
    // Hazard view: registered bitmap, minus any same-cycle release when bypassing.
    eff_busy     = busy_q & ~release_mask;
    issue_ready  = (issue_rd == AW'(X0_ADDR)) || !eff_busy[issue_rd];
    issue_fire   = issue_valid && issue_ready;
    if (issue_fire && (issue_rd != AW'(X0_ADDR))) set_mask[issue_rd] = 1'b1;
    rs1_busy     = (rs1_addr != AW'(X0_ADDR)) && eff_busy[rs1_addr];
    rs2_busy     = (rs2_addr != AW'(X0_ADDR)) && eff_busy[rs2_addr];
    wb_unclaimed = wb_fire && (wb_rd != AW'(X0_ADDR)) && !busy_q[wb_rd];
  end

  // A set and clear of the same index in one edge leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  assign busy_map = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU
// writeback, with a registered write port and a busy scoreboard (bypass: WBARB_WB_BYPASS_EN).
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                          WBARB_CLOCK_50,
  input  logic                          WBARB_RESET_InHigh,
  input  logic                          ISSUE_Valid,
  input  logic [REG_ADDR_WIDTH-1:0]     ISSUE_Rd,
  output logic                          ISSUE_Ready,
  input  logic [REG_ADDR_WIDTH-1:0]     RS1_Addr,
  input  logic [REG_ADDR_WIDTH-1:0]     RS2_Addr,
  output logic                          RS1_Busy,
  output logic                          RS2_Busy,
  input  logic                          SRC0_Valid,
  input  logic [REG_ADDR_WIDTH-1:0]     SRC0_Rd,
  input  logic [DATA_WIDTH-1:0]         SRC0_Data,
  output logic                          SRC0_Ready,
  input  logic                          SRC1_Valid,
  input  logic [REG_ADDR_WIDTH-1:0]     SRC1_Rd,
  input  logic [DATA_WIDTH-1:0]         SRC1_Data,
  output logic                          SRC1_Ready,
  output logic                          WP_En,
  output logic [REG_ADDR_WIDTH-1:0]     WP_Sel,
  output logic [DATA_WIDTH-1:0]         WP_Data,
  output logic [(2**REG_ADDR_WIDTH)-1:0] BUSY_Map,
  output logic                          WB_Err
);

  // Handshake: a transfer fires when Valid and Ready are both high at a rising
  // edge; Ready is combinational from Valids and the pointer, and a source
  // holds Rd/Data stable until it fires.
  src_id_t                     ptr_q;
  logic                        fire0;
  logic                        fire1;
  logic                        wb_fire;
  logic [REG_ADDR_WIDTH-1:0]   wb_rd;
  logic [DATA_WIDTH-1:0]       wb_data;
  logic                        wb_write;
  logic                        wb_unclaimed;

  always_comb begin
    SRC0_Ready = SRC0_Valid && (!SRC1_Valid || (ptr_q == SRC_ALU));
    SRC1_Ready = SRC1_Valid && (!SRC0_Valid || (ptr_q == SRC_LSU));
    fire0      = SRC0_Valid && SRC0_Ready;
    fire1      = SRC1_Valid && SRC1_Ready;
    wb_fire    = fire0 || fire1;
    wb_rd      = fire1 ? SRC1_Rd   : SRC0_Rd;
    wb_data    = fire1 ? SRC1_Data : SRC0_Data;
    wb_write   = wb_fire && (wb_rd != REG_ADDR_WIDTH'(X0_ADDR));
  end

  // The preferred source only rotates when both sources compete.
  always_ff @(posedge WBARB_CLOCK_50 or posedge WBARB_RESET_InHigh) begin
    if (WBARB_RESET_InHigh)           ptr_q <= SRC_ALU;
    else if (SRC0_Valid && SRC1_Valid) ptr_q <= (ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
  end

  always_ff @(posedge WBARB_CLOCK_50 or posedge WBARB_RESET_InHigh) begin
    if (WBARB_RESET_InHigh) begin
      WP_En   <= 1'b0;
      WP_Sel  <= '0;
      WP_Data <= '0;
      WB_Err  <= 1'b0;
    end else begin
      WP_En <= wb_write;
      if (wb_write) begin
        WP_Sel  <= wb_rd;
        WP_Data <= wb_data;
      end
      if (wb_unclaimed) WB_Err <= 1'b1;
    end
  end

  wb_scoreboard #(.AW(REG_ADDR_WIDTH)) u_scoreboard (
    .clk          (WBARB_CLOCK_50),
    .rst          (WBARB_RESET_InHigh),
    .issue_valid  (ISSUE_Valid),
    .issue_rd     (ISSUE_Rd),
    .wb_fire      (wb_fire),
    .wb_rd        (wb_rd),
    .rs1_addr     (RS1_Addr),
    .rs2_addr     (RS2_Addr),
    .issue_ready  (ISSUE_Ready),
    .rs1_busy     (RS1_Busy),
    .rs2_busy     (RS2_Busy),
    .wb_unclaimed (wb_unclaimed),
    .busy_map     (BUSY_Map)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: write-port scoreboard plus
// direct checks of grants, hazards, x0 handling, error flag and reset.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_ready;
  logic [AW-1:0] rs1_addr = '0;
  logic [AW-1:0] rs2_addr = '0;
  logic          rs1_busy, rs2_busy;
  logic          src0_valid = 1'b0, src1_valid = 1'b0;
  logic [AW-1:0] src0_rd = '0, src1_rd = '0;
  logic [DW-1:0] src0_data = '0, src1_data = '0;
  logic          src0_ready, src1_ready;
  logic          wp_en;
  logic [AW-1:0] wp_sel;
  logic [DW-1:0] wp_data;
  logic [31:0]   busy_map;
  logic          wb_err;

  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .WBARB_CLOCK_50     (clk),
    .WBARB_RESET_InHigh (rst),
    .ISSUE_Valid        (issue_valid),
    .ISSUE_Rd           (issue_rd),
    .ISSUE_Ready        (issue_ready),
    .RS1_Addr           (rs1_addr),
    .RS2_Addr           (rs2_addr),
    .RS1_Busy           (rs1_busy),
    .RS2_Busy           (rs2_busy),
    .SRC0_Valid         (src0_valid),
    .SRC0_Rd            (src0_rd),
    .SRC0_Data          (src0_data),
    .SRC0_Ready         (src0_ready),
    .SRC1_Valid         (src1_valid),
    .SRC1_Rd            (src1_rd),
    .SRC1_Data          (src1_data),
    .SRC1_Ready         (src1_ready),
    .WP_En              (wp_en),
    .WP_Sel             (wp_sel),
    .WP_Data            (wp_data),
    .BUSY_Map           (busy_map),
    .WB_Err             (wb_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write-port strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && wp_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wp_unexpected: got sel=%0d data=%0h expected no write", wp_sel, wp_data);
      end else begin
        check("wp_write", {wp_sel, wp_data}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic expect_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    step();
    issue_valid = 1'b0;
  endtask

  int cnt0, cnt1;

  initial begin
    // reset state
    at_neg();
    check("rst_busy_map", busy_map, 0);
    check("rst_wp_en", wp_en, 0);
    check("rst_wp_sel", wp_sel, 0);
    check("rst_wp_data", wp_data, 0);
    check("rst_wb_err", wb_err, 0);
    step();
    rst = 1'b0;
    step();

    // contention: src0 granted first, then src1
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    at_neg();
    check("issue_ready_rd5", issue_ready, 1);
    step();
    issue(5'd6);
    check("busy_after_issue", busy_map, 32'h0000_0060);
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    at_neg();
    check("rs1_busy_rd5", rs1_busy, 1);
    check("rs2_busy_x0", rs2_busy, 0);
    step();
    src0_valid = 1'b1; src0_rd = 5'd5; src0_data = 32'hAAAA_0001;
    src1_valid = 1'b1; src1_rd = 5'd6; src1_data = 32'h5555_0002;
    at_neg();
    check("contend_c0_ready", {src1_ready, src0_ready}, 2'b01);
    expect_write(5'd5, 32'hAAAA_0001);
    step();
    src0_valid = 1'b0;
    at_neg();
    check("contend_c1_ready", {src1_ready, src0_ready}, 2'b10);
    expect_write(5'd6, 32'h5555_0002);
    step();
    src1_valid = 1'b0;
    at_neg();
    check("contend_busy_end", busy_map, 0);
    check("contend_no_err", wb_err, 0);
    step();

    // WAW/RAW stall on rd7
    issue(5'd7);
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
    at_neg();
    check("waw_stall", issue_ready, 0);
    check("raw_stall", rs1_busy, 1);
    step();
    src0_valid = 1'b1; src0_rd = 5'd7; src0_data = 32'h0000_0077;
    at_neg();
`ifdef WBARB_WB_BYPASS_EN
    check("waw_bypass_release", issue_ready, 1);
    check("raw_bypass_release", rs1_busy, 0);
`else
    check("waw_still_stalled", issue_ready, 0);
    check("raw_still_stalled", rs1_busy, 1);
`endif
    expect_write(5'd7, 32'h0000_0077);
    step();
    src0_valid = 1'b0;
`ifndef WBARB_WB_BYPASS_EN
    at_neg();
    check("waw_release", issue_ready, 1);
    check("raw_release", rs1_busy, 0);
    step();
`endif
    issue_valid = 1'b0;
    at_neg();
    check("rd7_reclaimed", busy_map, 32'h0000_0080);
    step();
    src1_valid = 1'b1; src1_rd = 5'd7; src1_data = 32'h0000_7777;
    expect_write(5'd7, 32'h0000_7777);
    step();
    src1_valid = 1'b0;
    at_neg();
    check("rd7_cleared", busy_map, 0);
    step();

    // x0 writeback and x0 issue
    src1_valid = 1'b1; src1_rd = 5'd0; src1_data = 32'hDEAD_BEEF;
    at_neg();
    check("x0_wb_ready", src1_ready, 1);
    step();
    src1_valid = 1'b0;
    at_neg();
    check("x0_wp_en", wp_en, 0);
    check("x0_no_err", wb_err, 0);
    step();
    issue_valid = 1'b1; issue_rd = 5'd0;
    at_neg();
    check("x0_issue_ready", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    at_neg();
    check("x0_busy_unchanged", busy_map, 0);
    step();

    // protocol error: write to an unclaimed register
    src0_valid = 1'b1; src0_rd = 5'd9; src0_data = 32'h9999_0009;
    expect_write(5'd9, 32'h9999_0009);
    step();
    src0_valid = 1'b0;
    at_neg();
    check("err_set", wb_err, 1);
    step();
    step();
    at_neg();
    check("err_sticky", wb_err, 1);
    step();

    // fairness: pointer currently prefers src1, so grants go 1,0,1,0...
    cnt0 = 0; cnt1 = 0;
    src0_valid = 1'b1; src0_rd = 5'd10; src0_data = 32'hA0A0_0010;
    src1_valid = 1'b1; src1_rd = 5'd11; src1_data = 32'hB0B0_0011;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      check("fair_grant", {src1_ready, src0_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (src0_ready) cnt0++;
      if (src1_ready) cnt1++;
      if (i % 2 == 0) expect_write(5'd11, 32'hB0B0_0011);
      else            expect_write(5'd10, 32'hA0A0_0010);
      step();
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    check("fair_cnt0", cnt0, 4);
    check("fair_cnt1", cnt1, 4);
    at_neg();
    check("fair_err_sticky", wb_err, 1);
    step();

    // reset mid-burst with BUSY_Map=0xF0 and a write on the port
    for (int r = 4; r <= 8; r++) issue(AW'(r));
    src0_valid = 1'b1; src0_rd = 5'd8; src0_data = 32'h0000_0088;
    expect_write(5'd8, 32'h0000_0088);
    step();
    src0_valid = 1'b0;
    check("pre_rst_busy", busy_map, 32'h0000_00F0);
    check("pre_rst_wp_en", wp_en, 1);
    at_neg();
    #2;
    rst = 1'b1;
    issue_rd = 5'd4;
    rs1_addr = 5'd5;
    #1;
    check("midrst_busy", busy_map, 0);
    check("midrst_wp_en", wp_en, 0);
    check("midrst_wp_sel", wp_sel, 0);
    check("midrst_wp_data", wp_data, 0);
    check("midrst_wb_err", wb_err, 0);
    check("midrst_issue_ready", issue_ready, 1);
    check("midrst_rs1_busy", rs1_busy, 0);
    step();
    at_neg();
    rst = 1'b0;
    src0_valid = 1'b1; src0_rd = 5'd4; src0_data = 32'h0000_0044;
    src1_valid = 1'b1; src1_rd = 5'd5; src1_data = 32'h0000_0055;
    #1;
    check("post_rst_grant", {src1_ready, src0_ready}, 2'b01);
    expect_write(5'd4, 32'h0000_0044);
    step();
    src0_valid = 1'b0; src1_valid = 1'b0;
    step();
    step();
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
